// File: rtl/counter99_pkg.sv
// Shared types and constants for the counter99 count bus and its display.
// Holds the converter state encoding, segment patterns and the digit lookup.
// Pure declarations; no logic of its own.
package counter99_pkg;

  // Converter states: waiting for a new value, running shift-add-3, publishing.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Largest value that has a two-digit decimal representation.
  localparam logic [6:0] MAX_COUNT = 7'd99;

  // Number of shift-add-3 iterations, one per bit of the binary input.
  localparam int unsigned BIN_W = 7;

  // Active-low segment patterns, bit0 = a .. bit6 = g.
  localparam logic [6:0] SEG_DASH  = 7'b0111111;  // only g lit
  localparam logic [6:0] SEG_BLANK = 7'b1111111;  // everything off

  // Digit 0..9 to active-low pattern; anything else shows a dash.
  function automatic logic [6:0] seg_lookup(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows the input continuously.
module seg7_decode
  import counter99_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Table lookup; codes 10..15 render as a dash.
  always_comb begin
    seg = seg_lookup(digit);
  end

endmodule

// File: rtl/count_display_driver.sv
// Binary 0..127 to two BCD digits via sequential double-dabble, driving a
// 2-digit multiplexed active-low seven-segment display.
// Latency: value latched at edge k, digits/conv_done visible after edge k+8.
// Backpressure: none; value changes during a conversion are picked up on return to IDLE.
module count_display_driver
  import counter99_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] value,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       busy,
  output logic       conv_done,
  output logic       ovf
);

  // Refresh counter width; REFRESH_DIV is at least 2 so this is at least 1.
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);

  // Converter control
  state_t     state_q, state_d;
  logic       load_en;
  logic       shift_en;
  logic       done_en;

  // Conversion datapath
  logic [6:0] bin_q;
  logic [7:0] acc_q;
  logic [7:0] acc_adj;
  logic [2:0] iter_q;
  logic [6:0] latched_q;

  // Published results
  logic [6:0] shown_q, shown_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       ovf_q, ovf_d;
  logic       done_q, done_d;

  // Display refresh
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          refresh_wrap;
  logic          tens_slot;
  logic [3:0]    slot_digit;
  logic [6:0]    slot_pat;

  // ---------------------------------------------------------------------
  // Converter FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start on any difference from the displayed value, run one
  // iteration per input bit, then spend a single cycle publishing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (value != shown_q) state_d = ST_SHIFT;
      ST_SHIFT: if (iter_q == 3'(BIN_W - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath strobes decoded from the current state.
  always_comb begin
    busy     = 1'b0;
    load_en  = 1'b0;
    shift_en = 1'b0;
    done_en  = 1'b0;
    case (state_q)
      ST_IDLE:  load_en = (value != shown_q);
      ST_SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
      end
      ST_DONE:  begin
        busy    = 1'b1;
        done_en = 1'b1;
      end
      default:  busy = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Double-dabble datapath
  // ---------------------------------------------------------------------

  // Add-3 correction on each BCD nibble that would overflow on doubling.
  always_comb begin
    acc_adj = acc_q;
    if (acc_q[3:0] >= 4'd5) acc_adj[3:0] = acc_q[3:0] + 4'd3;
    if (acc_q[7:4] >= 4'd5) acc_adj[7:4] = acc_q[7:4] + 4'd3;
  end

  // Load a fresh conversion or shift {acc, bin} left by one.
  // The hundreds carry falls off the top; values above 99 are flagged
  // separately so a truncated accumulator is never published.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q     <= '0;
      acc_q     <= '0;
      iter_q    <= '0;
      latched_q <= '0;
    end else if (load_en) begin
      bin_q     <= value;
      acc_q     <= '0;
      iter_q    <= '0;
      latched_q <= value;
    end else if (shift_en) begin
      acc_q  <= {acc_adj[6:0], bin_q[6]};
      bin_q  <= {bin_q[5:0], 1'b0};
      iter_q <= iter_q + 3'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------

  // Publish digits (or the overflow marker) in the DONE cycle only.
  always_comb begin
    shown_d = shown_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (done_en) begin
      shown_d = latched_q;
      done_d  = 1'b1;
      if (latched_q > MAX_COUNT) begin
        tens_d = 4'hF;
        ones_d = 4'hF;
        ovf_d  = 1'b1;
      end else begin
        tens_d = acc_q[7:4];
        ones_d = acc_q[3:0];
        ovf_d  = 1'b0;
      end
    end
  end

  // Result register bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      shown_q <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shown_q <= shown_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------
  // Display refresh mux
  // ---------------------------------------------------------------------

  // Slot timer and anode rotation; the anode flips when the timer wraps.
  always_comb begin
    refresh_wrap = (cnt_q == LAST_CNT);
    cnt_d        = refresh_wrap ? '0 : cnt_q + CW'(1);
    an_d         = refresh_wrap ? ~an_q : an_q;
  end

  // Segment pattern is computed from next-cycle anode and next-cycle digits
  // so a slot change and a fresh result landing together never mix.
  always_comb begin
    tens_slot  = (an_d[1] == 1'b0);
    slot_digit = tens_slot ? tens_d : ones_d;
  end

  seg7_decode u_seg7_decode (
    .digit (slot_digit),
    .seg   (slot_pat)
  );

  // Leading-zero blanking applies to the tens slot only, never to a dash.
  always_comb begin
    seg_d = slot_pat;
    if (BLANK_LZ && tens_slot && (tens_d == 4'd0) && !ovf_d) begin
      seg_d = SEG_BLANK;
    end
  end

  // Refresh register bank; reset shows '0' on the ones digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      an_q  <= 2'b10;
      seg_q <= 7'b1000000;
    end else begin
      cnt_q <= cnt_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign bcd_tens  = tens_q;
  assign bcd_ones  = ones_q;
  assign ovf       = ovf_q;
  assign conv_done = done_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver with a fast refresh rate.
// Compares every cycle against a behavioural model plus literal spot checks.
// Stimulus: directed scenarios followed by free-running and random values.
module tb_count_display_driver;

  localparam int RDIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] value;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       busy;
  logic       conv_done;
  logic       ovf;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;
  bit win_en = 1'b0;
  int win_dones = 0;
  logic [3:0] win_first_t, win_first_o;
  bit seen20 = 1'b0;

  count_display_driver #(.REFRESH_DIV(RDIV), .BLANK_LZ(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .seg       (seg),
    .an        (an),
    .bcd_tens  (bcd_tens),
    .bcd_ones  (bcd_ones),
    .busy      (busy),
    .conv_done (conv_done),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Conversion modelled as "8 cycles after latching, digits = v/10, v%10".
  int         m_cnt;
  logic [6:0] m_lat, m_shown;
  logic [3:0] m_tens, m_ones;
  bit         m_ovf, m_done;
  int         m_ref;
  bit         m_tslot;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= 0; m_lat <= 0; m_shown <= 0; m_tens <= 0; m_ones <= 0;
      m_ovf <= 0; m_done <= 0; m_ref <= 0; m_tslot <= 0;
    end else begin
      m_done <= 0;
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done  <= 1;
          m_shown <= m_lat;
          if (m_lat > 7'd99) begin
            m_tens <= 4'hF; m_ones <= 4'hF; m_ovf <= 1;
          end else begin
            m_tens <= 4'(m_lat / 7'd10); m_ones <= 4'(m_lat % 7'd10); m_ovf <= 0;
          end
        end
      end else if (value != m_shown) begin
        m_lat <= value;
        m_cnt <= 8;
      end
      if (m_ref == RDIV - 1) begin
        m_ref <= 0; m_tslot <= !m_tslot;
      end else begin
        m_ref <= m_ref + 1;
      end
    end
  end

  function automatic logic [6:0] exp_seg(bit tslot, logic [3:0] t, logic [3:0] o, bit ov);
    logic [3:0] d;
    d = tslot ? t : o;
    if (ov || d > 4'd9) return 7'b0111111;
    if (tslot && d == 4'd0) return 7'b1111111;
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("seg",       {25'd0, seg},       {25'd0, exp_seg(m_tslot, m_tens, m_ones, m_ovf)});
      check("an",        {30'd0, an},        m_tslot ? 32'd1 : 32'd2);
      check("bcd_tens",  {28'd0, bcd_tens},  {28'd0, m_tens});
      check("bcd_ones",  {28'd0, bcd_ones},  {28'd0, m_ones});
      check("busy",      {31'd0, busy},      (m_cnt > 0) ? 32'd1 : 32'd0);
      check("conv_done", {31'd0, conv_done}, {31'd0, m_done});
      check("ovf",       {31'd0, ovf},       {31'd0, m_ovf});
      if (conv_done === 1'b1) begin
        done_cnt++;
        if (win_en) begin
          if (win_dones == 0) begin
            win_first_t = bcd_tens; win_first_o = bcd_ones;
          end
          win_dones++;
          if (bcd_tens == 4'd2 && bcd_ones == 4'd0) seen20 = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the given anode slot is active, then check seg.
  task automatic slot_seg(input string name, input logic [1:0] want_an, input logic [6:0] want_seg);
    int k;
    k = 0;
    while (an !== want_an && k < 20) begin
      tick(1);
      k++;
    end
    if (k >= 20) begin
      tests++; fails++;
      $display("FAIL %s: slot %0b not reached, an=%0b", name, want_an, an);
    end else begin
      check(name, {25'd0, seg}, {25'd0, want_seg});
    end
  endtask

  int d0;
  int cnt99;

  initial begin
    reset = 1'b1;
    value = 7'd0;
    tick(1);
    chk_en = 1'b1;
    tick(1);
    reset = 1'b0;

    // Reset state and 20 idle cycles without a conversion.
    check("rst_tens", {28'd0, bcd_tens}, 32'd0);
    check("rst_ones", {28'd0, bcd_ones}, 32'd0);
    check("rst_an",   {30'd0, an},       32'b10);
    check("rst_seg",  {25'd0, seg},      32'b1000000);
    check("rst_busy", {31'd0, busy},     32'd0);
    d0 = done_cnt;
    tick(20);
    check("rst_no_done", done_cnt - d0, 0);

    // Basic conversion 0 -> 57 with exact timing.
    value = 7'd57;
    tick(1);
    check("b57_busy_k1", {31'd0, busy}, 32'd1);
    tick(7);
    check("b57_busy_k8", {31'd0, busy}, 32'd1);
    check("b57_nodone_k7", {31'd0, conv_done}, 32'd0);
    tick(1);
    check("b57_done", {31'd0, conv_done}, 32'd1);
    check("b57_tens", {28'd0, bcd_tens}, 32'd5);
    check("b57_ones", {28'd0, bcd_ones}, 32'd7);
    check("b57_ovf",  {31'd0, ovf}, 32'd0);
    tick(1);
    check("b57_done_pulse", {31'd0, conv_done}, 32'd0);

    // Maximum value.
    value = 7'd99;
    tick(10);
    check("m99_tens", {28'd0, bcd_tens}, 32'd9);
    check("m99_ones", {28'd0, bcd_ones}, 32'd9);
    slot_seg("m99_seg_tens", 2'b01, 7'b0010000);
    slot_seg("m99_seg_ones", 2'b10, 7'b0010000);

    // Overflow values, then recovery.
    value = 7'd100;
    tick(10);
    check("o100_ovf",  {31'd0, ovf}, 32'd1);
    check("o100_tens", {28'd0, bcd_tens}, 32'hF);
    check("o100_ones", {28'd0, bcd_ones}, 32'hF);
    slot_seg("o100_seg_tens", 2'b01, 7'b0111111);
    slot_seg("o100_seg_ones", 2'b10, 7'b0111111);
    value = 7'd127;
    tick(10);
    check("o127_ovf", {31'd0, ovf}, 32'd1);
    slot_seg("o127_seg_tens", 2'b01, 7'b0111111);
    value = 7'd42;
    tick(10);
    check("r42_ovf",  {31'd0, ovf}, 32'd0);
    check("r42_tens", {28'd0, bcd_tens}, 32'd4);
    check("r42_ones", {28'd0, bcd_ones}, 32'd2);

    // Value changes while busy: 10, then 20, then 30.
    win_en = 1'b1;
    value = 7'd10;
    tick(3);
    value = 7'd20;
    tick(2);
    value = 7'd30;
    tick(30);
    win_en = 1'b0;
    check("cwb_dones",   win_dones, 2);
    check("cwb_first_t", {28'd0, win_first_t}, 32'd1);
    check("cwb_first_o", {28'd0, win_first_o}, 32'd0);
    check("cwb_no20",    {31'd0, seen20}, 32'd0);
    check("cwb_tens",    {28'd0, bcd_tens}, 32'd3);
    check("cwb_ones",    {28'd0, bcd_ones}, 32'd0);

    // Leading-zero blanking.
    value = 7'd7;
    tick(10);
    slot_seg("blank_tens", 2'b01, 7'b1111111);
    slot_seg("blank_ones", 2'b10, 7'b1111000);

    // Reset in the middle of the shift phase.
    d0 = done_cnt;
    value = 7'd55;
    tick(4);
    reset = 1'b1;
    value = 7'd0;
    tick(1);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_tens", {28'd0, bcd_tens}, 32'd0);
    check("mrst_ones", {28'd0, bcd_ones}, 32'd0);
    check("mrst_an",   {30'd0, an}, 32'b10);
    check("mrst_seg",  {25'd0, seg}, 32'b1000000);
    reset = 1'b0;
    tick(12);
    check("mrst_no_done", done_cnt - d0, 0);

    // Free-running upstream counter 0..99 wrapping.
    cnt99 = 0;
    for (int s = 0; s < 150; s++) begin
      value = 7'(cnt99);
      tick($urandom_range(9, 12));
      cnt99 = (cnt99 == 99) ? 0 : cnt99 + 1;
    end

    // Random values, random hold times, occasional reset.
    for (int s = 0; s < 250; s++) begin
      value = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        tick($urandom_range(1, 3));
        reset = 1'b0;
      end
      tick($urandom_range(1, 14));
    end
    tick(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
